fast_field_dispatcher: RTL and testbench
========================================

# fast_field_dispatcher

Parametrised field-op dispatcher for the FAST decode path. It accepts one message's worth of per-field op words, issues them in field order to `NUM_DEC` field decoders over per-decoder valid/ready handshakes, and tracks completions. It signals when the whole message has retired. It sits between the template/pmap front end and the decoder array. It generalises the fixed-width scheduler with variable field count, per-decoder backpressure, same-cycle slot reuse and an optional watchdog.

## Interface
- `NUM_DEC`, 4, number of field decoders (≥1)
- `MAX_FIELDS`, 16, max fields per message (≥1)
- `OP_W`, 32, op word width per field
- `TIMEOUT`, 255, watchdog limit in cycles (used only with watchdog)
- Derived: `FIDX_W = $clog2(MAX_FIELDS)` (min 1), `FCNT_W = $clog2(MAX_FIELDS+1)`

Ports:
- `clk`  in  1  sole clock, all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `msg_valid`  in  1  new message offered
- `msg_ready`  out  1  dispatcher idle, can accept
- `msg_num_fields`  in  FCNT_W  field count of offered message (0..MAX_FIELDS)
- `msg_ops`  in  OP_W × MAX_FIELDS  op word per field, index = field number
- `dec_valid`  out  NUM_DEC  op offered to decoder d
- `dec_ready`  in  NUM_DEC  decoder d accepts
- `dec_op`  out  OP_W × NUM_DEC  op word for decoder d
- `dec_idx`  out  FIDX_W × NUM_DEC  field number carried with op
- `dec_done`  in  NUM_DEC  one-cycle pulse: decoder d finished its field
- `fields_done`  out  FCNT_W  fields retired in current/last message
- `busy`  out  1  message in flight
- `msg_done`  out  1  one-cycle pulse, message fully retired
- `msg_abort`  out  1  one-cycle pulse, watchdog abort (tied 0 without macro)

## Operation
- Top FSM: IDLE → ISSUE → DRAIN → DONE → IDLE.
- IDLE: `msg_ready`=1. On `msg_valid && msg_ready`, the block latches `msg_ops` and `msg_num_fields`. It clears `fields_done` and `next_ptr`, then enters ISSUE. A count of 0 goes straight to DONE. A count >MAX_FIELDS is clamped to MAX_FIELDS.
- Per-decoder slot FSM: FREE → OFFER → BUSY → FREE/OFFER.
  - OFFER holds `dec_valid`=1 with stable `dec_op`/`dec_idx` until `dec_ready`.
  - Handshake cycle moves the slot to BUSY.
  - `dec_done` in BUSY retires the field: `fields_done` +1 per retiring slot, popcount of same-cycle retirements.
- Allocation each cycle in ISSUE:
  - Eligible slots are those FREE, plus those BUSY with `dec_done` this cycle.
  - Eligible slots take consecutive field numbers from `next_ptr` in ascending decoder index.
  - `next_ptr` advances by the number assigned. No field is issued twice or skipped.
- ISSUE → DRAIN when `next_ptr == num_fields`. DRAIN → DONE when all slots FREE. DONE: `msg_done`=1 for one cycle, then IDLE.
- `dec_done` on a slot not in BUSY is ignored. `dec_ready` without `dec_valid` is ignored.
- `busy`=1 in ISSUE, DRAIN, DONE.
- `fields_done` holds its final value in IDLE until the next message is accepted.

## Timing
- Reset values:
  - all `dec_valid`/`dec_op`/`dec_idx` = 0
  - `fields_done`, `busy`, `msg_done`, `msg_abort` = 0
  - `msg_ready` = 1
  - all slots FREE, FSM IDLE
- Accept at edge t → first `dec_valid` (decoders 0..min(NUM_DEC,n)-1) at t+1.
- `dec_done` at edge t with fields remaining → that slot OFFERs the next field at t+1 (no idle cycle).
- Last slot frees at edge t → `msg_done` at t+1 → `msg_ready` at t+2.
- A zero-field message accepted at t → `msg_done` at t+1.
- `rst` mid-message: next edge returns everything to reset values. No `msg_done`, no `msg_abort`.

## Configuration
- `FAST_DISPATCH_WATCHDOG_EN` defined:
  - Each slot has a counter, cleared on entering OFFER/BUSY and incremented each cycle in OFFER or BUSY.
  - When any counter reaches `TIMEOUT`, the block drops all `dec_valid` next edge and frees all slots.
  - It pulses `msg_abort` one cycle and returns to IDLE without `msg_done`. `fields_done` holds.
- Not defined: no counters, `msg_abort` tied 0, a stalled decoder stalls the message indefinitely.

## Test plan
- NUM_DEC=4, 10 fields, all `dec_ready`=1, each `dec_done` 3 cycles after accept → `dec_idx` 0–3 at t+1, field 4 reissued to the first decoder finishing. `msg_done` once, `fields_done`=10.
- Decoder 2 holds `dec_ready`=0 for 5 cycles → `dec_valid[2]`, `dec_op[2]` and `dec_idx[2]` stay stable. No other field takes index 2.
- Decoders 0 and 3 pulse `dec_done` the same cycle with 6 fields left → fields 4 (dec 0) and 5 (dec 3) offered next cycle. `fields_done` +2.
- `msg_num_fields`=0 → `msg_done` one cycle after accept, no `dec_valid`. With 2 fields on 4 decoders, only `dec_valid[1:0]` assert.
- `rst` asserted mid-DRAIN → all outputs at reset values next cycle, `msg_ready`=1, no `msg_done`.
- With `FAST_DISPATCH_WATCHDOG_EN`, TIMEOUT=8, decoder 1 never pulses `dec_done` → `msg_abort` pulse, all `dec_valid`=0, `msg_done` never asserted.

Source files
------------

// File: rtl/fast_field_dispatcher.sv
// fast_field_dispatcher: issues one message's per-field op words, in field order,
//   to NUM_DEC decoders over valid/ready, counts completions and flags message retirement.
// Latency: accept edge -> first dec_valid next cycle; dec_done -> re-offer next cycle;
//   last retirement edge -> msg_done next cycle.
// Backpressure: msg_ready only while idle; each decoder offer holds op/idx stable until
//   dec_ready, and a stalled decoder stalls the message.
// Ports: msg_valid/msg_ready/msg_num_fields/msg_ops accept side; dec_valid/dec_ready/dec_op/
//   dec_idx/dec_done per-decoder side; fields_done/busy/msg_done/msg_abort status.
// Optional per-slot watchdog enabled by defining FAST_DISPATCH_WATCHDOG_EN.
module fast_field_dispatcher #(
  parameter int NUM_DEC    = 4,
  parameter int MAX_FIELDS = 16,
  parameter int OP_W       = 32,
  parameter int TIMEOUT    = 255,
  localparam int FIDX_W    = (MAX_FIELDS > 1) ? $clog2(MAX_FIELDS) : 1,
  localparam int FCNT_W    = $clog2(MAX_FIELDS + 1)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         msg_valid,
  output logic                         msg_ready,
  input  logic [FCNT_W-1:0]            msg_num_fields,
  input  logic [MAX_FIELDS*OP_W-1:0]   msg_ops,
  output logic [NUM_DEC-1:0]           dec_valid,
  input  logic [NUM_DEC-1:0]           dec_ready,
  output logic [NUM_DEC*OP_W-1:0]      dec_op,
  output logic [NUM_DEC*FIDX_W-1:0]    dec_idx,
  input  logic [NUM_DEC-1:0]           dec_done,
  output logic [FCNT_W-1:0]            fields_done,
  output logic                         busy,
  output logic                         msg_done,
  output logic                         msg_abort
);

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_DRAIN, ST_DONE} state_e;
  typedef enum logic [1:0] {SL_FREE, SL_OFFER, SL_BUSY} slot_e;

  state_e                     state_q, state_d;
  slot_e                      slot_q [NUM_DEC];
  slot_e                      slot_d [NUM_DEC];
  logic [MAX_FIELDS*OP_W-1:0] ops_q, ops_d;
  logic [FCNT_W-1:0]          num_q, num_d;
  logic [FCNT_W-1:0]          ptr_q, ptr_d;
  logic [FCNT_W-1:0]          fdone_q, fdone_d;
  logic [NUM_DEC*OP_W-1:0]    op_q, op_d;
  logic [NUM_DEC*FIDX_W-1:0]  idx_q, idx_d;
  logic                       accept;
  logic [FCNT_W-1:0]          num_clamped;

  assign accept      = (state_q == ST_IDLE) && msg_valid;
  assign num_clamped = (msg_num_fields > FCNT_W'(MAX_FIELDS)) ? FCNT_W'(MAX_FIELDS)
                                                               : msg_num_fields;

`ifdef FAST_DISPATCH_WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);
  logic [WD_W-1:0] wd_cnt_q [NUM_DEC];
  logic            wd_hit;
  logic            abort_q, abort_d;

  always_comb begin
    wd_hit = 1'b0;
    for (int d = 0; d < NUM_DEC; d++) begin
      if (slot_q[d] != SL_FREE && wd_cnt_q[d] == WD_W'(TIMEOUT)) wd_hit = 1'b1;
    end
  end

  // Counter restarts on every slot state change, so OFFER and BUSY are timed separately.
  always_ff @(posedge clk) begin
    for (int d = 0; d < NUM_DEC; d++) begin
      if (rst || wd_hit || slot_d[d] == SL_FREE || slot_d[d] != slot_q[d]) begin
        wd_cnt_q[d] <= '0;
      end else if (wd_cnt_q[d] != WD_W'(TIMEOUT)) begin
        wd_cnt_q[d] <= wd_cnt_q[d] + WD_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) abort_q <= 1'b0;
    else     abort_q <= abort_d;
  end

  assign msg_abort = abort_q;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT == 0);
  assign msg_abort      = 1'b0;
`endif

  always_comb begin
    logic [MAX_FIELDS*OP_W-1:0] src_ops;
    logic [FCNT_W-1:0]          src_num;
    logic [FCNT_W-1:0]          ptr_v;
    logic [FCNT_W-1:0]          retired;
    logic                       eligible;
    logic                       all_free;

    state_d = state_q;
    slot_d  = slot_q;
    ops_d   = ops_q;
    num_d   = num_q;
    ptr_d   = ptr_q;
    fdone_d = fdone_q;
    op_d    = op_q;
    idx_d   = idx_q;
`ifdef FAST_DISPATCH_WATCHDOG_EN
    abort_d = 1'b0;
`endif

    // On the accept edge, allocate straight from the input bus so the first
    // offers appear one cycle after acceptance.
    src_ops  = accept ? msg_ops : ops_q;
    src_num  = accept ? num_clamped : num_q;
    ptr_v    = accept ? '0 : ptr_q;
    retired  = '0;
    all_free = 1'b1;

    for (int d = 0; d < NUM_DEC; d++) begin
      eligible = 1'b0;
      case (slot_q[d])
        SL_FREE:  eligible = 1'b1;
        SL_OFFER: if (dec_ready[d]) slot_d[d] = SL_BUSY;
        SL_BUSY: begin
          if (dec_done[d]) begin
            slot_d[d] = SL_FREE;
            retired   = retired + FCNT_W'(1);
            eligible  = 1'b1;  // same-cycle reuse of a retiring slot
          end
        end
        default:  slot_d[d] = SL_FREE;
      endcase

      // Ascending decoder index takes consecutive field numbers.
      if ((accept || state_q == ST_ISSUE) && eligible && (ptr_v < src_num)) begin
        slot_d[d]                 = SL_OFFER;
        op_d[d*OP_W +: OP_W]      = src_ops[ptr_v[FIDX_W-1:0]*OP_W +: OP_W];
        idx_d[d*FIDX_W +: FIDX_W] = ptr_v[FIDX_W-1:0];
        ptr_v                     = ptr_v + FCNT_W'(1);
      end

      if (slot_d[d] != SL_FREE) all_free = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          ops_d   = msg_ops;
          num_d   = num_clamped;
          ptr_d   = ptr_v;
          fdone_d = '0;
          state_d = (num_clamped == '0) ? ST_DONE : ST_ISSUE;
        end
      end
      ST_ISSUE, ST_DRAIN: begin
        ptr_d   = ptr_v;
        fdone_d = fdone_q + retired;
        // Jump to DONE on the same edge the last slot frees.
        if (ptr_v == num_q) state_d = all_free ? ST_DONE : ST_DRAIN;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

`ifdef FAST_DISPATCH_WATCHDOG_EN
    if (wd_hit) begin
      for (int d = 0; d < NUM_DEC; d++) slot_d[d] = SL_FREE;
      ptr_d   = ptr_q;
      fdone_d = fdone_q;
      state_d = ST_IDLE;
      abort_d = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      for (int d = 0; d < NUM_DEC; d++) slot_q[d] <= SL_FREE;
      ops_q   <= '0;
      num_q   <= '0;
      ptr_q   <= '0;
      fdone_q <= '0;
      op_q    <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      ops_q   <= ops_d;
      num_q   <= num_d;
      ptr_q   <= ptr_d;
      fdone_q <= fdone_d;
      op_q    <= op_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    dec_valid = '0;
    for (int d = 0; d < NUM_DEC; d++) dec_valid[d] = (slot_q[d] == SL_OFFER);
  end

  assign dec_op      = op_q;
  assign dec_idx     = idx_q;
  assign fields_done = fdone_q;
  assign msg_ready   = (state_q == ST_IDLE);
  assign busy        = (state_q != ST_IDLE);
  assign msg_done    = (state_q == ST_DONE);

endmodule

// File: tb/tb_fast_field_dispatcher.sv
// tb_fast_field_dispatcher: directed stimulus with a per-decoder scoreboard of expected
//   issues and a queue of expected message completions, checked by a negedge monitor.
module tb_fast_field_dispatcher;
  localparam int NUM_DEC    = 4;
  localparam int MAX_FIELDS = 16;
  localparam int OP_W       = 32;
  localparam int TIMEOUT    = 8;
  localparam int FIDX_W     = 4;
  localparam int FCNT_W     = 5;

  logic                        clk = 1'b0;
  logic                        rst;
  logic                        msg_valid;
  logic                        msg_ready;
  logic [FCNT_W-1:0]           msg_num_fields;
  logic [MAX_FIELDS*OP_W-1:0]  msg_ops;
  logic [NUM_DEC-1:0]          dec_valid;
  logic [NUM_DEC-1:0]          dec_ready;
  logic [NUM_DEC*OP_W-1:0]     dec_op;
  logic [NUM_DEC*FIDX_W-1:0]   dec_idx;
  logic [NUM_DEC-1:0]          dec_done;
  logic [FCNT_W-1:0]           fields_done;
  logic                        busy;
  logic                        msg_done;
  logic                        msg_abort;

  fast_field_dispatcher #(
    .NUM_DEC(NUM_DEC), .MAX_FIELDS(MAX_FIELDS), .OP_W(OP_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst),
    .msg_valid(msg_valid), .msg_ready(msg_ready),
    .msg_num_fields(msg_num_fields), .msg_ops(msg_ops),
    .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_op(dec_op), .dec_idx(dec_idx),
    .dec_done(dec_done), .fields_done(fields_done), .busy(busy),
    .msg_done(msg_done), .msg_abort(msg_abort)
  );

  initial forever #5 clk = ~clk;

  typedef struct packed {
    logic [FIDX_W-1:0] idx;
    logic [OP_W-1:0]   op;
  } item_t;

  int    total = 0;
  int    bad   = 0;
  item_t exp_q [NUM_DEC][$];
  int    exp_done_q [$];
  int    lat [NUM_DEC];
  int    cnt [NUM_DEC];
  bit    abort_ok = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  task automatic flag(input string name);
    total++;
    bad++;
    $display("FAIL %s", name);
  endtask

  function automatic logic [OP_W-1:0] op_of(input int m, input int i);
    return 32'hA500_0000 | (32'(m) << 8) | 32'(i);
  endfunction

  function automatic item_t mk(input int m, input int i);
    item_t it;
    it.idx = FIDX_W'(i);
    it.op  = op_of(m, i);
    return it;
  endfunction

  // Monitor (checks first) followed by the decoder model, both on the negedge.
  initial begin
    item_t it;
    dec_done = '0;
    for (int d = 0; d < NUM_DEC; d++) cnt[d] = 0;
    forever begin
      @(negedge clk);
      for (int d = 0; d < NUM_DEC; d++) begin
        if (dec_valid[d] && dec_ready[d]) begin
          if (exp_q[d].size() == 0) begin
            flag($sformatf("unexpected_issue_d%0d idx=%0d", d, dec_idx[d*FIDX_W +: FIDX_W]));
          end else begin
            it = exp_q[d].pop_front();
            check($sformatf("issue_idx_d%0d", d), dec_idx[d*FIDX_W +: FIDX_W], it.idx);
            check($sformatf("issue_op_d%0d", d), dec_op[d*OP_W +: OP_W], it.op);
          end
        end
      end
      if (msg_done) begin
        if (exp_done_q.size() == 0) flag("unexpected_msg_done");
        else check("msg_done_fields", fields_done, exp_done_q.pop_front());
      end
      if (msg_abort && !abort_ok) flag("unexpected_msg_abort");

      for (int d = 0; d < NUM_DEC; d++) begin
        dec_done[d] = 1'b0;
        if (rst) begin
          cnt[d] = 0;
        end else begin
          if (cnt[d] > 0) begin
            cnt[d]--;
            if (cnt[d] == 0) dec_done[d] = 1'b1;
          end
          if (dec_valid[d] && dec_ready[d] && lat[d] > 0) cnt[d] = lat[d];
        end
      end
    end
  end

  task automatic set_lat(input int l0, input int l1, input int l2, input int l3);
    lat[0] = l0; lat[1] = l1; lat[2] = l2; lat[3] = l3;
  endtask

  // Equal latencies on all decoders: field i lands on decoder i % NUM_DEC.
  task automatic expect_rr(input int m, input int n);
    for (int i = 0; i < n; i++) exp_q[i % NUM_DEC].push_back(mk(m, i));
    exp_done_q.push_back(n);
  endtask

  // Called at posedge+1 while idle; returns at posedge+1 after the accept edge.
  task automatic send(input int m, input int n);
    logic [MAX_FIELDS*OP_W-1:0] ops;
    ops = '0;
    for (int i = 0; i < MAX_FIELDS; i++) ops[i*OP_W +: OP_W] = op_of(m, i);
    msg_ops        = ops;
    msg_num_fields = FCNT_W'(n);
    msg_valid      = 1'b1;
    @(posedge clk);
    #1 msg_valid   = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int k;
    k = 0;
    while (!(msg_ready && exp_done_q.size() == 0) && k < 300) begin
      @(posedge clk);
      #1;
      k++;
    end
    for (int d = 0; d < NUM_DEC; d++)
      check($sformatf("%s_pending_d%0d", name, d), exp_q[d].size(), 0);
    check({name, "_pending_done"}, exp_done_q.size(), 0);
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst            = 1'b1;
    msg_valid      = 1'b0;
    msg_num_fields = '0;
    msg_ops        = '0;
    dec_ready      = '1;
    set_lat(1, 1, 1, 1);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_msg_ready", msg_ready, 1);
    check("rst_dec_valid", dec_valid, 0);
    check("rst_dec_op", dec_op[63:0], 0);
    check("rst_dec_idx", dec_idx, 0);
    check("rst_fields_done", fields_done, 0);
    check("rst_busy", busy, 0);
    check("rst_msg_done", msg_done, 0);
    check("rst_msg_abort", msg_abort, 0);
    @(posedge clk); #1;

    // 10 fields, every decoder finishes 3 cycles after its handshake
    set_lat(3, 3, 3, 3);
    expect_rr(1, 10);
    send(1, 10);
    @(negedge clk);
    check("t1_first_valid", dec_valid, 4'hF);
    check("t1_first_idx", dec_idx, 16'h3210);
    check("t1_busy", busy, 1);
    check("t1_fields_done_cleared", fields_done, 0);
    wait_idle("t1");
    check("t1_fields_done_hold", fields_done, 10);

    // Decoder 2 refuses for 5 cycles: its offer must stay frozen
    set_lat(2, 2, 2, 2);
    dec_ready = 4'b1011;
    exp_q[0].push_back(mk(2, 0)); exp_q[0].push_back(mk(2, 4));
    exp_q[1].push_back(mk(2, 1)); exp_q[1].push_back(mk(2, 5));
    exp_q[2].push_back(mk(2, 2));
    exp_q[3].push_back(mk(2, 3));
    exp_done_q.push_back(6);
    send(2, 6);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check($sformatf("t2_valid2_c%0d", k), dec_valid[2], 1);
      check($sformatf("t2_op2_c%0d", k), dec_op[2*OP_W +: OP_W], op_of(2, 2));
      check($sformatf("t2_idx2_c%0d", k), dec_idx[2*FIDX_W +: FIDX_W], 2);
    end
    @(posedge clk);
    #1 dec_ready = '1;
    wait_idle("t2");

    // Decoders 0 and 3 retire together with 6 fields left
    set_lat(3, 5, 6, 3);
    exp_q[0].push_back(mk(3, 0)); exp_q[0].push_back(mk(3, 4)); exp_q[0].push_back(mk(3, 8));
    exp_q[1].push_back(mk(3, 1)); exp_q[1].push_back(mk(3, 6));
    exp_q[2].push_back(mk(3, 2)); exp_q[2].push_back(mk(3, 7));
    exp_q[3].push_back(mk(3, 3)); exp_q[3].push_back(mk(3, 5)); exp_q[3].push_back(mk(3, 9));
    exp_done_q.push_back(10);
    send(3, 10);
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("t3_reoffer_valid", dec_valid, 4'b1001);
    check("t3_reoffer_idx0", dec_idx[0 +: FIDX_W], 4);
    check("t3_reoffer_idx3", dec_idx[3*FIDX_W +: FIDX_W], 5);
    check("t3_fields_done_plus2", fields_done, 2);
    wait_idle("t3");

    // Zero-field message
    set_lat(1, 1, 1, 1);
    exp_done_q.push_back(0);
    send(4, 0);
    @(negedge clk);
    check("t4_zero_done", msg_done, 1);
    check("t4_zero_no_valid", dec_valid, 0);
    check("t4_zero_busy", busy, 1);
    @(negedge clk);
    check("t4_zero_done_pulse", msg_done, 0);
    check("t4_zero_ready", msg_ready, 1);
    @(posedge clk); #1;
    wait_idle("t4a");

    // Two fields on four decoders, plus last-free -> msg_done -> msg_ready timing
    expect_rr(5, 2);
    send(5, 2);
    @(negedge clk);
    check("t4_two_valid", dec_valid, 4'b0011);
    @(negedge clk);
    check("t4_two_not_done_yet", msg_done, 0);
    @(negedge clk);
    check("t4_two_done", msg_done, 1);
    check("t4_two_not_ready", msg_ready, 0);
    @(negedge clk);
    check("t4_two_ready", msg_ready, 1);
    check("t4_two_done_pulse", msg_done, 0);
    @(posedge clk); #1;
    wait_idle("t4b");

    // Oversized count is clamped to MAX_FIELDS
    expect_rr(6, MAX_FIELDS);
    send(6, 20);
    wait_idle("t5");
    check("t5_clamped_fields_done", fields_done, MAX_FIELDS);

    // Reset while draining
    set_lat(20, 20, 20, 20);
    exp_q[0].push_back(mk(7, 0));
    exp_q[1].push_back(mk(7, 1));
    send(7, 2);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("t6_pre_busy", busy, 1);
    check("t6_pre_no_valid", dec_valid, 0);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("t6_rst_dec_valid", dec_valid, 0);
    check("t6_rst_dec_idx", dec_idx, 0);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_msg_ready", msg_ready, 1);
    check("t6_rst_fields_done", fields_done, 0);
    check("t6_rst_msg_done", msg_done, 0);
    check("t6_rst_msg_abort", msg_abort, 0);
    repeat (30) @(posedge clk);
    #1;
    wait_idle("t6");

`ifdef FAST_DISPATCH_WATCHDOG_EN
    // Decoder 1 never completes: watchdog aborts the message
    begin
      int k;
      set_lat(2, 0, 2, 2);
      abort_ok = 1'b1;
      for (int i = 0; i < 4; i++) exp_q[i].push_back(mk(8, i));
      send(8, 4);
      k = 0;
      while (!msg_abort && k < 40) begin
        @(negedge clk);
        k++;
      end
      check("t7_abort_seen", msg_abort, 1);
      check("t7_valid_dropped", dec_valid, 0);
      check("t7_ready", msg_ready, 1);
      check("t7_fields_done_hold", fields_done, 3);
      @(negedge clk);
      check("t7_abort_pulse", msg_abort, 0);
      @(posedge clk); #1;
      wait_idle("t7");
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
